// File: rtl/burst_ram_slave.sv
// Burst-capable 4 KiB RAM slave on a multiplexed address/data bus.
// Reads return the first word two cycles after begin; writes store one word per qualified cycle.
module burst_ram_slave #(
  parameter logic [31:0] baseAddress  = 32'h5000_0000,
  parameter int unsigned addressWidth = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        beginTransactionIn,
  input  logic [31:0] addressDataIn,
  input  logic        readNotWriteIn,
  input  logic [7:0]  burstSizeIn,
  input  logic [3:0]  byteEnablesIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  input  logic        busyIn,
  output logic [31:0] addressDataOut,
  output logic        dataValidOut,
  output logic        endTransactionOut,
  output logic        busErrorOut
);

  localparam int unsigned Depth = 1 << addressWidth;
  localparam logic [addressWidth-1:0] PtrOne = 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_FETCH,
    READ_BURST,
    WRITE,
    END,
    ERROR
  } state_t;

  state_t                  state_q, state_d;
  logic [addressWidth-1:0] ptr_q, ptr_d;
  logic [7:0]              beats_q, beats_d;
  logic                    data_valid_q, data_valid_d;
  logic                    end_q, end_d;
  logic                    err_q, err_d;
  logic                    rd_en, wr_en;
  logic [addressWidth-1:0] rd_addr, wr_addr;
  logic [31:0]             rd_word;
  logic                    claim;

  assign claim = beginTransactionIn && (addressDataIn[31:12] == baseAddress[31:12]);

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    beats_d      = beats_q;
    data_valid_d = 1'b0;
    end_d        = 1'b0;
    err_d        = 1'b0;
    rd_en        = 1'b0;
    wr_en        = 1'b0;
    case (state_q)
      IDLE: begin
        if (claim) begin
          if (addressDataIn[1:0] != 2'b00) begin
            state_d = ERROR;
            end_d   = 1'b1;
            err_d   = 1'b1;
          end else begin
            ptr_d   = addressDataIn[addressWidth+1:2];
            beats_d = burstSizeIn;
            state_d = readNotWriteIn ? READ_FETCH : WRITE;
          end
        end
      end
      READ_FETCH: begin
        if (endTransactionIn) begin
          state_d = IDLE;
        end else begin
          rd_en        = 1'b1;
          ptr_d        = ptr_q + PtrOne;
          data_valid_d = 1'b1;
          state_d      = READ_BURST;
        end
      end
      READ_BURST: begin
        // beats_q counts words still to fetch after the one currently on the bus
        if (endTransactionIn) begin
          state_d = IDLE;
        end else if (busyIn) begin
          data_valid_d = 1'b1;
        end else if (beats_q != 8'd0) begin
          rd_en        = 1'b1;
          ptr_d        = ptr_q + PtrOne;
          beats_d      = beats_q - 8'd1;
          data_valid_d = 1'b1;
        end else begin
          end_d   = 1'b1;
          state_d = END;
        end
      end
      WRITE: begin
        if (dataValidIn) begin
          wr_en = 1'b1;
          ptr_d = ptr_q + PtrOne;
          if (beats_q == 8'd0) begin
            state_d = IDLE;
          end else begin
            beats_d = beats_q - 8'd1;
          end
        end
        if (endTransactionIn) begin
          state_d = IDLE;
        end
      end
      END:     state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      beats_q      <= 8'd0;
      data_valid_q <= 1'b0;
      end_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      beats_q      <= beats_d;
      data_valid_q <= data_valid_d;
      end_q        <= end_d;
      err_q        <= err_d;
    end
  end

  // Simple dual-port storage: one byte-lane array per lane, write port and registered read port.
  assign wr_addr = ptr_q;
  assign rd_addr = ptr_q;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [0:Depth-1];
      logic [7:0] rd_q;
      always_ff @(posedge clock) begin
        if (wr_en && byteEnablesIn[gi]) begin
          mem[wr_addr] <= addressDataIn[8*gi +: 8];
        end
        if (rd_en) begin
          rd_q <= mem[rd_addr];
        end
      end
      assign rd_word[8*gi +: 8] = rd_q;
    end
  endgenerate

  // Read data is held in the RAM output register; gating by valid keeps the bus at 0 otherwise.
  assign addressDataOut    = data_valid_q ? rd_word : 32'd0;
  assign dataValidOut      = data_valid_q;
  assign endTransactionOut = end_q;
  assign busErrorOut       = err_q;

endmodule

// File: tb/tb_burst_ram_slave.sv
// Directed self-checking bench for burst_ram_slave: bursts, wrap, stalls, errors, aborts, reset.
module tb_burst_ram_slave;

  logic        clock = 1'b0;
  logic        reset;
  logic        beginTransactionIn;
  logic [31:0] addressDataIn;
  logic        readNotWriteIn;
  logic [7:0]  burstSizeIn;
  logic [3:0]  byteEnablesIn;
  logic        dataValidIn;
  logic        endTransactionIn;
  logic        busyIn;
  logic [31:0] addressDataOut;
  logic        dataValidOut;
  logic        endTransactionOut;
  logic        busErrorOut;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] wdata [0:7];
  logic [31:0] rexp  [0:7];
  logic [63:0] busy_mask;

  burst_ram_slave dut (
    .clock             (clock),
    .reset             (reset),
    .beginTransactionIn(beginTransactionIn),
    .addressDataIn     (addressDataIn),
    .readNotWriteIn    (readNotWriteIn),
    .burstSizeIn       (burstSizeIn),
    .byteEnablesIn     (byteEnablesIn),
    .dataValidIn       (dataValidIn),
    .endTransactionIn  (endTransactionIn),
    .busyIn            (busyIn),
    .addressDataOut    (addressDataOut),
    .dataValidOut      (dataValidOut),
    .endTransactionOut (endTransactionOut),
    .busErrorOut       (busErrorOut)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    beginTransactionIn = 1'b0;
    addressDataIn      = 32'd0;
    readNotWriteIn     = 1'b0;
    burstSizeIn        = 8'd0;
    byteEnablesIn      = 4'd0;
    dataValidIn        = 1'b0;
    endTransactionIn   = 1'b0;
    busyIn             = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_data"}, addressDataOut, 32'd0);
    check({tag, "_flags"}, {29'd0, dataValidOut, endTransactionOut, busErrorOut}, 32'd0);
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [7:0] bsz, input int nwords,
                             input logic [3:0] be, input int end_at);
    $display("txn write addr=%h burst=%0d words=%0d be=%b end_at=%0d", addr, bsz, nwords, be, end_at);
    beginTransactionIn = 1'b1;
    addressDataIn      = addr;
    readNotWriteIn     = 1'b0;
    burstSizeIn        = bsz;
    tick();
    beginTransactionIn = 1'b0;
    for (int i = 0; i < nwords; i++) begin
      dataValidIn      = 1'b1;
      addressDataIn    = wdata[i];
      byteEnablesIn    = be;
      endTransactionIn = (i == end_at);
      tick();
      check("wr_quiet", {29'd0, dataValidOut, endTransactionOut, busErrorOut}, 32'd0);
    end
    idle_inputs();
    tick();
  endtask

  task automatic read_burst(input string tag, input logic [31:0] addr, input logic [7:0] bsz,
                            input int end_cycle);
    int c;
    int k;
    $display("txn read %s addr=%h burst=%0d busy_mask=%h", tag, addr, bsz, busy_mask);
    beginTransactionIn = 1'b1;
    addressDataIn      = addr;
    readNotWriteIn     = 1'b1;
    burstSizeIn        = bsz;
    tick();
    idle_inputs();
    check({tag, "_fetch_valid"}, {31'd0, dataValidOut}, 32'd0);
    tick();
    c = 2;
    k = 0;
    while (k <= int'(bsz) && c < 64) begin
      check({tag, "_valid"}, {31'd0, dataValidOut}, 32'd1);
      check({tag, "_data"}, addressDataOut, rexp[k]);
      check({tag, "_end_err"}, {30'd0, endTransactionOut, busErrorOut}, 32'd0);
      busyIn = busy_mask[c];
      tick();
      if (!busy_mask[c]) k++;
      c++;
    end
    busyIn = 1'b0;
    if (c >= 64) check({tag, "_timeout"}, 32'd1, 32'd0);
    check({tag, "_end_cycle"}, 32'(c), 32'(end_cycle));
    check({tag, "_end_flags"}, {29'd0, dataValidOut, endTransactionOut, busErrorOut}, 32'b010);
    check({tag, "_end_data"}, addressDataOut, 32'd0);
    tick();
    check_quiet({tag, "_after"});
  endtask

  initial begin
    idle_inputs();
    busy_mask = 64'd0;
    reset = 1'b1;
    tick();
    tick();
    check_quiet("in_reset");
    reset = 1'b0;
    tick();
    check_quiet("post_reset");

    // Four-word write then readback: data at T+2..T+5, end at T+6
    wdata[0] = 32'h11; wdata[1] = 32'h22; wdata[2] = 32'h33; wdata[3] = 32'h44;
    write_burst(32'h5000_0010, 8'd3, 4, 4'hF, -1);
    rexp[0] = 32'h11; rexp[1] = 32'h22; rexp[2] = 32'h33; rexp[3] = 32'h44;
    read_burst("rd_basic", 32'h5000_0010, 8'd3, 6);

    // Byte-enable merge over a zeroed word
    wdata[0] = 32'h0000_0000;
    write_burst(32'h5000_0000, 8'd0, 1, 4'hF, -1);
    wdata[0] = 32'hAABB_CCDD;
    write_burst(32'h5000_0000, 8'd0, 1, 4'b0101, -1);
    rexp[0] = 32'h00BB_00DD;
    read_burst("rd_be", 32'h5000_0000, 8'd0, 3);

    // Window wrap: word 1023 then word 0
    wdata[0] = 32'hA000_0001; wdata[1] = 32'hB000_0002;
    write_burst(32'h5000_0FFC, 8'd1, 2, 4'hF, -1);
    rexp[0] = 32'hA000_0001; rexp[1] = 32'hB000_0002;
    read_burst("rd_wrap", 32'h5000_0FFC, 8'd1, 4);

    // Stall on T+3,T+4: second word held three cycles, end at T+8
    wdata[0] = 32'h0101_0101; wdata[1] = 32'h0202_0202; wdata[2] = 32'h0303_0303; wdata[3] = 32'h0404_0404;
    write_burst(32'h5000_0100, 8'd3, 4, 4'hF, -1);
    rexp[0] = 32'h0101_0101; rexp[1] = 32'h0202_0202; rexp[2] = 32'h0303_0303; rexp[3] = 32'h0404_0404;
    busy_mask = 64'b1_1000;
    read_burst("rd_busy", 32'h5000_0100, 8'd3, 8);
    busy_mask = 64'd0;

    // Early master end: beat with endTransactionIn stored, later beat ignored
    wdata[0] = 32'd0; wdata[1] = 32'd0; wdata[2] = 32'd0;
    write_burst(32'h5000_0200, 8'd2, 3, 4'hF, -1);
    wdata[0] = 32'hC1; wdata[1] = 32'hC2; wdata[2] = 32'hC3;
    write_burst(32'h5000_0200, 8'd7, 3, 4'hF, 1);
    rexp[0] = 32'hC1; rexp[1] = 32'hC2; rexp[2] = 32'h0;
    read_burst("rd_early_end", 32'h5000_0200, 8'd2, 5);

    // Misaligned begin: error and end for exactly one cycle
    $display("txn misaligned addr=50000002");
    beginTransactionIn = 1'b1;
    addressDataIn      = 32'h5000_0002;
    readNotWriteIn     = 1'b1;
    tick();
    idle_inputs();
    check("err_flags", {29'd0, dataValidOut, endTransactionOut, busErrorOut}, 32'b011);
    tick();
    check_quiet("err_after");

    // Out-of-window begin: no bus activity
    $display("txn foreign addr=60000000");
    beginTransactionIn = 1'b1;
    addressDataIn      = 32'h6000_0000;
    readNotWriteIn     = 1'b1;
    burstSizeIn        = 8'd3;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      check_quiet("foreign");
      tick();
    end

    // Master abort during read burst
    $display("txn read abort addr=50000010");
    beginTransactionIn = 1'b1;
    addressDataIn      = 32'h5000_0010;
    readNotWriteIn     = 1'b1;
    burstSizeIn        = 8'd3;
    tick();
    idle_inputs();
    tick();
    check("abort_first", addressDataOut, 32'h11);
    endTransactionIn = 1'b1;
    tick();
    endTransactionIn = 1'b0;
    check_quiet("abort_next");
    tick();
    check_quiet("abort_idle");

    // Reset mid read burst: outputs clear at once, memory keeps its contents
    $display("txn read reset addr=50000010");
    beginTransactionIn = 1'b1;
    addressDataIn      = 32'h5000_0010;
    readNotWriteIn     = 1'b1;
    burstSizeIn        = 8'd3;
    tick();
    idle_inputs();
    tick();
    tick();
    check("rst_mid_data", addressDataOut, 32'h22);
    reset = 1'b1;
    #1;
    check_quiet("rst_async");
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_quiet("rst_release");
    rexp[0] = 32'h11; rexp[1] = 32'h22; rexp[2] = 32'h33; rexp[3] = 32'h44;
    read_burst("rd_after_rst", 32'h5000_0010, 8'd3, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
